// File: rtl/gamepad_move_decoder.sv
// gamepad_move_decoder: turns the SNES button word into single-direction moves
// with hold-to-repeat timing, a Start press pulse and a controller-present flag.
module gamepad_move_decoder #(
    parameter int TICK_DIV         = 50000,
    parameter int REPEAT_DELAY_MS  = 400,
    parameter int REPEAT_PERIOD_MS = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] btn_state,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    input  logic        move_ready,
    output logic        start_pulse,
    output logic        connected
);
    localparam int MS_MAX = REPEAT_DELAY_MS > REPEAT_PERIOD_MS ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  DLY_LAST = MS_W'(REPEAT_DELAY_MS - 1);
    localparam logic [MS_W-1:0]  PER_LAST = MS_W'(REPEAT_PERIOD_MS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_DELAY, WAIT_PERIOD} state_t;

    state_t            state_q, state_d;
    logic [11:0]       btn_q, btn;
    logic [3:0]        dirs;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [1:0]        held_q, held_d, cur_dir, dir_q, dir_d;
    logic              cur_valid, ev, load, tick_end, period_end;
    logic              start_q, valid_q, valid_d;

    assign connected   = btn_q != 12'hFFF;
    assign btn         = connected ? btn_q : 12'h000;
    assign dirs        = btn[7:4];
    assign cur_valid   = $onehot(dirs);
    assign cur_dir     = dirs[3] ? 2'd0 : dirs[2] ? 2'd1 : dirs[1] ? 2'd2 : 2'd3;
    assign start_pulse = btn[8] & ~start_q;
    assign tick_end    = pre_q == PRE_LAST;
    assign period_end  = tick_end && ms_q == (state_q == WAIT_DELAY ? DLY_LAST : PER_LAST);

    // Counters default to clear; they only advance while the same direction stays held.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        pre_d   = '0;
        ms_d    = '0;
        ev      = 1'b0;
        if (state_q == IDLE) begin
            if (cur_valid) begin
                ev      = 1'b1;
                held_d  = cur_dir;
                state_d = WAIT_DELAY;
            end
        end else if (!cur_valid) begin
            state_d = IDLE;
        end else if (cur_dir != held_q || period_end) begin
            ev      = 1'b1;
            held_d  = cur_dir;
            state_d = cur_dir != held_q ? WAIT_DELAY : WAIT_PERIOD;
        end else begin
            pre_d = tick_end ? '0 : pre_q + PRE_W'(1);
            ms_d  = ms_q + MS_W'(tick_end);
        end
    end

    // An event is dropped while an unaccepted move is pending.
    assign load    = ev && (!valid_q || move_ready);
    assign valid_d = load ? 1'b1 : valid_q && !move_ready;
    assign dir_d   = load ? cur_dir : dir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q   <= 12'hFFF;
            state_q <= IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            held_q  <= 2'd0;
            valid_q <= 1'b0;
            dir_q   <= 2'd0;
            start_q <= 1'b0;
        end else begin
            btn_q   <= btn_state;
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            start_q <= btn[8];
        end
    end

    assign move_valid = valid_q;
    assign move_dir   = dir_q;
endmodule

// File: tb/tb_gamepad_move_decoder.sv
// tb_gamepad_move_decoder: directed vectors with hand-computed expectations,
// using TICK_DIV=4, REPEAT_DELAY_MS=3 (12 cycles), REPEAT_PERIOD_MS=2 (8 cycles).
module tb_gamepad_move_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] btn_state = 12'h000;
    logic        move_valid, move_ready = 1'b1, start_pulse, connected;
    logic [1:0]  move_dir;
    int          checks = 0, failures = 0;
    int          mv, st;

    gamepad_move_decoder #(.TICK_DIV(4), .REPEAT_DELAY_MS(3), .REPEAT_PERIOD_MS(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_state(btn_state), .move_valid(move_valid),
        .move_dir(move_dir), .move_ready(move_ready), .start_pulse(start_pulse), .connected(connected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts accepted handshakes and start pulses seen at each sample point, then steps.
    task automatic run(input int n, output int moves, output int starts);
        moves = 0;
        starts = 0;
        for (int i = 0; i < n; i++) begin
            if (move_valid && move_ready) moves++;
            if (start_pulse) starts++;
            step(1);
        end
    endtask

    initial begin
        step(3);
        check("rst_valid", move_valid, 0);
        check("rst_dir", move_dir, 0);
        check("rst_start", start_pulse, 0);
        check("rst_conn", connected, 0);
        rst_n = 1'b1;
        step(1);
        check("post_rst_conn", connected, 1);
        check("post_rst_valid", move_valid, 0);

        // Hold Up: first move at edge 2, repeats at 14, 22, 30
        btn_state = 12'h080;
        step(1);
        check("up_e1", move_valid, 0);
        step(1);
        check("up_e2_valid", move_valid, 1);
        check("up_e2_dir", move_dir, 0);
        step(1);
        check("up_e3", move_valid, 0);
        step(10);
        check("up_e13", move_valid, 0);
        step(1);
        check("up_e14", move_valid, 1);
        step(7);
        check("up_e21", move_valid, 0);
        step(1);
        check("up_e22", move_valid, 1);
        step(8);
        check("up_e30", move_valid, 1);
        btn_state = 12'h000;
        run(6, mv, st);
        check("up_release_moves", mv, 1);
        check("up_release_valid", move_valid, 0);

        // Left held then released at cycle 10: one move only
        btn_state = 12'h020;
        step(2);
        check("left_valid", move_valid, 1);
        check("left_dir", move_dir, 2);
        run(8, mv, st);
        check("left_hold_moves", mv, 1);
        btn_state = 12'h000;
        run(20, mv, st);
        check("left_no_repeat", mv, 0);

        // Right with consumer stalled: pending move held, repeats dropped
        move_ready = 1'b0;
        btn_state = 12'h010;
        step(2);
        check("stall_valid", move_valid, 1);
        check("stall_dir", move_dir, 3);
        step(28);
        check("stall_hold_valid", move_valid, 1);
        check("stall_hold_dir", move_dir, 3);
        btn_state = 12'h000;
        step(2);
        check("stall_release_valid", move_valid, 1);
        move_ready = 1'b1;
        run(10, mv, st);
        check("stall_accept_once", mv, 1);

        // Two directions at once give nothing; Down then switch to Right restarts delay
        btn_state = 12'h0A0;
        run(10, mv, st);
        check("multi_dir_none", mv, 0);
        btn_state = 12'h040;
        step(2);
        check("down_valid", move_valid, 1);
        check("down_dir", move_dir, 1);
        step(3);
        btn_state = 12'h010;
        step(2);
        check("switch_valid", move_valid, 1);
        check("switch_dir", move_dir, 3);
        run(12, mv, st);
        check("switch_restart_moves", mv, 1);
        check("switch_repeat_valid", move_valid, 1);
        check("switch_repeat_dir", move_dir, 3);
        btn_state = 12'h000;
        run(4, mv, st);
        check("switch_drain", mv, 1);

        // Disconnected word, then reconnect with Start held
        btn_state = 12'hFFF;
        run(10, mv, st);
        check("disc_moves", mv, 0);
        check("disc_starts", st, 0);
        check("disc_conn", connected, 0);
        btn_state = 12'h100;
        run(6, mv, st);
        check("reconn_starts", st, 1);
        check("reconn_moves", mv, 0);
        check("reconn_conn", connected, 1);
        btn_state = 12'h000;
        step(2);
        btn_state = 12'h900;
        run(6, mv, st);
        check("start_again", st, 1);

        // Reset mid-WAIT_PERIOD with a pending move, Up still held after release
        btn_state = 12'h080;
        step(2);
        check("rr_first_valid", move_valid, 1);
        move_ready = 1'b0;
        step(14);
        rst_n = 1'b0;
        step(1);
        check("rr_valid", move_valid, 0);
        check("rr_start", start_pulse, 0);
        check("rr_conn", connected, 0);
        step(1);
        rst_n = 1'b1;
        move_ready = 1'b1;
        step(1);
        check("rr_e1_valid", move_valid, 0);
        check("rr_e1_conn", connected, 1);
        step(1);
        check("rr_e2_valid", move_valid, 1);
        check("rr_e2_dir", move_dir, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
